spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter_if.sv | 28 ++
 rtl/spi_arbiter.sv | 117 +++++++++++
 tb/tb_spi_arbiter.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arbiter_if.sv
// Signal bundle between the two requesters, the shared byte-level SPI master and spi_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's view.
interface spi_arbiter_if;
   logic        req0;
   logic        req1;
   logic [23:0] cmd0;
   logic [23:0] cmd1;
   logic        done0;
   logic        done1;
   logic [7:0]  rdata;
   logic        busy;
   logic        spi_start;
   logic [7:0]  spi_din;
   logic [7:0]  spi_dout;
   logic        spi_ready;
   logic        spi_done_tick;
   logic        cs;

   modport slave (
      input  req0, req1, cmd0, cmd1, spi_dout, spi_ready, spi_done_tick,
      output done0, done1, rdata, busy, spi_start, spi_din, cs
   );

   modport master (
      output req0, req1, cmd0, cmd1, spi_dout, spi_ready, spi_done_tick,
      input  done0, done1, rdata, busy, spi_start, spi_din, cs
   );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one byte-level SPI master between two requesters.
// Each grant runs a fixed three-byte transaction under cs, followed by a CS_GAP-cycle deselect gap.
module spi_arbiter #(
   parameter int CS_GAP = 10
) (
   input logic         clk,
   input logic         reset,
   spi_arbiter_if.slave bus
);

   localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

   state_t        state, state_d;
   logic [23:0]   cmd_q, cmd_d;
   logic [1:0]    idx_q, idx_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          owner_q, owner_d;   // requester granted most recently
   logic          cs_q, cs_d;
   logic          done0_q, done0_d;
   logic          done1_q, done1_d;
   logic [7:0]    rdata_q, rdata_d;
   logic [7:0]    byte_sel;

   always_comb begin
      unique case (idx_q)
         2'd0:    byte_sel = cmd_q[23:16];
         2'd1:    byte_sel = cmd_q[15:8];
         default: byte_sel = cmd_q[7:0];
      endcase
   end

   // spi_din follows the latched command and byte index only, so it cannot move while a byte is in flight.
   assign bus.spi_din   = byte_sel;
   assign bus.spi_start = (state == SEND) && bus.spi_ready;
   assign bus.busy      = (state != IDLE);
   assign bus.cs        = cs_q;
   assign bus.done0     = done0_q;
   assign bus.done1     = done1_q;
   assign bus.rdata     = rdata_q;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case can infer a latch.
      state_d = state;
      cmd_d   = cmd_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      owner_d = owner_q;
      cs_d    = cs_q;
      done0_d = 1'b0;
      done1_d = 1'b0;
      rdata_d = rdata_q;

      unique case (state)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               owner_d = (bus.req0 && bus.req1) ? ~owner_q : bus.req1;
               cmd_d   = owner_d ? bus.cmd1 : bus.cmd0;
               cs_d    = 1'b0;
               idx_d   = 2'd0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (bus.spi_ready) state_d = WAIT;
         end
         WAIT: begin
            if (bus.spi_done_tick) begin
               if (idx_q == 2'd2) begin
                  rdata_d = bus.spi_dout;
                  done0_d = ~owner_q;
                  done1_d = owner_q;
                  cs_d    = 1'b1;
                  gap_d   = GW'(CS_GAP - 1);
                  idx_d   = 2'd0;
                  state_d = GAP;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = SEND;
               end
            end
         end
         GAP: begin
            if (gap_q == '0) state_d = IDLE;
            else             gap_d   = gap_q - GW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cmd_q   <= '0;
         idx_q   <= '0;
         gap_q   <= '0;
         owner_q <= 1'b1;
         cs_q    <= 1'b1;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state   <= state_d;
         cmd_q   <= cmd_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         owner_q <= owner_d;
         cs_q    <= cs_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Randomised self-checking bench for spi_arbiter: a behavioural SPI master, a bus monitor
// and a transaction-level reference model of round-robin grants, byte order and read data.
module tb_spi_arbiter;
   localparam int CS_GAP = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   spi_arbiter_if bus ();

   spi_arbiter #(.CS_GAP(CS_GAP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int         tests_run = 0;
   int         tests_failed = 0;
   int         model_last = 1;
   int         byte_time = 2;
   int         stall_left = 0;
   bit         inject_tick = 1'b0;
   bit         fixed_dout_en = 1'b0;
   logic [7:0] fixed_dout = 8'h00;
   logic [7:0] last_tick_dout = 8'h00;
   logic [7:0] rdata_model = 8'h00;
   int         start_total = 0;
   logic [7:0] sent_q[$];

   function automatic int model_grant(input bit r0, input bit r1, input int last);
      if (r0 && r1) return (last == 0) ? 1 : 0;
      return r0 ? 0 : 1;
   endfunction

   // Behavioural SPI master: one byte takes byte_time cycles from the cycle after spi_start.
   task automatic master_loop();
      int         m_cnt = 0;
      int         handled = 0;
      logic [7:0] v;
      forever begin
         @(posedge clk);
         #1;
         bus.spi_done_tick = 1'b0;
         if (!reset) begin
            m_cnt = 0;
            handled = start_total;
            bus.spi_ready = 1'b1;
         end else begin
            if (handled != start_total) begin
               handled = start_total;
               m_cnt = byte_time;
            end
            if (m_cnt > 0) begin
               bus.spi_ready = 1'b0;
               m_cnt--;
               if (m_cnt == 0) begin
                  v = fixed_dout_en ? fixed_dout : 8'($urandom);
                  bus.spi_dout = v;
                  last_tick_dout = v;
                  bus.spi_done_tick = 1'b1;
               end
            end else if (inject_tick) begin
               inject_tick = 1'b0;
               bus.spi_dout = 8'($urandom);
               bus.spi_done_tick = 1'b1;
            end else if (stall_left > 0) begin
               bus.spi_ready = 1'b0;
               stall_left--;
            end else begin
               bus.spi_ready = 1'b1;
            end
         end
      end
   endtask

   // Continuous protocol checks, sampled on the falling edge.
   task automatic monitor_loop();
      int         gap_run = 0;
      bit         in_byte = 1'b0;
      logic [7:0] din_at_start = 8'h00;
      forever begin
         @(negedge clk);
         if (!reset) begin
            in_byte = 1'b0;
            gap_run = 0;
            rdata_model = 8'h00;
         end else begin
            tests_run++;
            if (bus.done0 === 1'b1 && bus.done1 === 1'b1) begin
               tests_failed++;
               $display("FAIL done_overlap: done0=%b done1=%b required not both high", bus.done0, bus.done1);
            end
            if (bus.spi_start === 1'b1) begin
               sent_q.push_back(bus.spi_din);
               start_total++;
               din_at_start = bus.spi_din;
               in_byte = 1'b1;
               tests_run++;
               if (bus.cs !== 1'b0) begin
                  tests_failed++;
                  $display("FAIL cs_at_start: cs=%b required 0", bus.cs);
               end
            end else if (in_byte) begin
               tests_run++;
               if (bus.spi_din !== din_at_start) begin
                  tests_failed++;
                  $display("FAIL din_stable: spi_din=%h required %h", bus.spi_din, din_at_start);
               end
               if (bus.spi_done_tick === 1'b1) in_byte = 1'b0;
            end
            if (bus.done0 === 1'b1 || bus.done1 === 1'b1) begin
               rdata_model = last_tick_dout;
               tests_run++;
               if (bus.cs !== 1'b1) begin
                  tests_failed++;
                  $display("FAIL cs_at_done: cs=%b required 1", bus.cs);
               end
            end
            tests_run++;
            if (bus.rdata !== rdata_model) begin
               tests_failed++;
               $display("FAIL rdata: rdata=%h required %h", bus.rdata, rdata_model);
            end
            if (bus.busy === 1'b1 && bus.cs === 1'b1) begin
               gap_run++;
            end else if (bus.busy === 1'b0 && gap_run > 0) begin
               tests_run++;
               if (gap_run != CS_GAP) begin
                  tests_failed++;
                  $display("FAIL cs_gap: gap cycles=%0d required %0d", gap_run, CS_GAP);
               end
               gap_run = 0;
            end
         end
      end
   endtask

   task automatic wait_busy(input logic level, input string name);
      int n = 0;
      while (bus.busy !== level && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy !== level) begin
         tests_run++;
         tests_failed++;
         $display("FAIL %s_timeout: busy=%b required %b within 2000 cycles", name, bus.busy, level);
      end
   endtask

   task automatic wait_done(output int id, output int cycles, input string name);
      id = -1;
      cycles = 0;
      while (cycles < 2000) begin
         @(negedge clk);
         cycles++;
         if (bus.done0 === 1'b1 || bus.done1 === 1'b1) begin
            id = (bus.done1 === 1'b1) ? 1 : 0;
            break;
         end
      end
      if (id < 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL %s_done_timeout: no done pulse, required one within 2000 cycles", name);
      end
   endtask

   task automatic check_bytes(input int n0, input logic [23:0] exp_cmd, input string name);
      tests_run++;
      if (sent_q.size() != n0 + 3) begin
         tests_failed++;
         $display("FAIL %s_starts: spi_start count=%0d required 3", name, sent_q.size() - n0);
      end else begin
         for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (sent_q[n0+k] !== exp_cmd[23-8*k -: 8]) begin
               tests_failed++;
               $display("FAIL %s_byte%0d: spi_din=%h required %h", name, k, sent_q[n0+k], exp_cmd[23-8*k -: 8]);
            end
         end
      end
   endtask

   // One transaction through the reference model; optional request drop / command overwrite after grant.
   task automatic do_txn(input bit r0, input bit r1, input logic [23:0] c0, input logic [23:0] c1,
                         input bit drop, input bit scramble, input logic [23:0] new_cmd,
                         input int t, input string name);
      int          exp_id, got_id, cyc, n0;
      logic [23:0] exp_cmd;
      wait_busy(1'b0, name);
      byte_time = t;
      bus.cmd0 = c0;
      bus.cmd1 = c1;
      bus.req0 = r0;
      bus.req1 = r1;
      exp_id = model_grant(r0, r1, model_last);
      model_last = exp_id;
      exp_cmd = (exp_id == 1) ? c1 : c0;
      n0 = sent_q.size();
      wait_busy(1'b1, name);
      @(negedge clk);
      if (drop) begin
         bus.req0 = 1'b0;
         bus.req1 = 1'b0;
      end
      if (scramble) begin
         bus.cmd0 = new_cmd;
         bus.cmd1 = new_cmd;
      end
      wait_done(got_id, cyc, name);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      tests_run++;
      if (got_id !== exp_id) begin
         tests_failed++;
         $display("FAIL %s_grant: done from requester %0d required %0d", name, got_id, exp_id);
      end
      check_bytes(n0, exp_cmd, name);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_last = 1;
   endtask

   task automatic test_reset();
      logic [20:0] exp_vec;
      exp_vec = {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
      reset = 1'b1;
      #3 reset = 1'b0;
      #1;
      tests_run++;
      if ({bus.cs, bus.busy, bus.spi_start, bus.spi_din, bus.done0, bus.done1, bus.rdata} !== exp_vec) begin
         tests_failed++;
         $display("FAIL reset_async: outputs=%h required %h", {bus.cs, bus.busy, bus.spi_start, bus.spi_din,
                  bus.done0, bus.done1, bus.rdata}, exp_vec);
      end
      repeat (2) @(negedge clk);
      tests_run++;
      if ({bus.cs, bus.busy, bus.spi_start, bus.spi_din, bus.done0, bus.done1, bus.rdata} !== exp_vec) begin
         tests_failed++;
         $display("FAIL reset_held: outputs=%h required %h", {bus.cs, bus.busy, bus.spi_start, bus.spi_din,
                  bus.done0, bus.done1, bus.rdata}, exp_vec);
      end
      reset = 1'b1;
      model_last = 1;
   endtask

   task automatic test_single();
      int          id, cyc, g, n0, exp_lat;
      logic [23:0] exp_cmd;
      wait_busy(1'b0, "single");
      byte_time = 2;
      fixed_dout_en = 1'b1;
      fixed_dout = 8'h5A;
      exp_cmd = 24'h0B0800;
      exp_lat = 1 + 3 * (byte_time + 1);
      n0 = sent_q.size();
      bus.cmd0 = exp_cmd;
      bus.req0 = 1'b1;
      wait_done(id, cyc, "single");
      bus.req0 = 1'b0;
      model_last = 0;
      tests_run++;
      if (id !== 0) begin
         tests_failed++;
         $display("FAIL single_grant: done from requester %0d required 0", id);
      end
      tests_run++;
      if (cyc != exp_lat) begin
         tests_failed++;
         $display("FAIL single_latency: %0d cycles required %0d", cyc, exp_lat);
      end
      tests_run++;
      if (bus.rdata !== 8'h5A) begin
         tests_failed++;
         $display("FAIL single_rdata: rdata=%h required 5a", bus.rdata);
      end
      check_bytes(n0, exp_cmd, "single");
      @(negedge clk);
      tests_run++;
      if ({bus.done0, bus.done1} !== 2'b00) begin
         tests_failed++;
         $display("FAIL single_done_width: done0/done1=%b required 00", {bus.done0, bus.done1});
      end
      g = 1;
      while (bus.busy === 1'b1 && g < 100) begin
         tests_run++;
         if (bus.cs !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_gap_cs: cs=%b required 1", bus.cs);
         end
         g++;
         @(negedge clk);
      end
      tests_run++;
      if (g != CS_GAP) begin
         tests_failed++;
         $display("FAIL single_gap_len: cs high %0d cycles before idle, required %0d", g, CS_GAP);
      end
      fixed_dout_en = 1'b0;
   endtask

   task automatic test_ready_stall();
      int          id, cyc, n0;
      logic [23:0] c;
      wait_busy(1'b0, "stall");
      byte_time = 1;
      c = 24'($urandom);
      stall_left = 8;
      @(negedge clk);
      n0 = sent_q.size();
      bus.cmd0 = c;
      bus.req0 = 1'b1;
      model_last = model_grant(1'b1, 1'b0, model_last);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         tests_run++;
         if ({bus.busy, bus.spi_start, bus.spi_din} !== {1'b1, 1'b0, c[23:16]}) begin
            tests_failed++;
            $display("FAIL stall_hold%0d: busy/start/din=%b/%b/%h required 1/0/%h", k, bus.busy,
                     bus.spi_start, bus.spi_din, c[23:16]);
         end
      end
      @(negedge clk);
      tests_run++;
      if ({bus.spi_start, bus.spi_din} !== {1'b1, c[23:16]}) begin
         tests_failed++;
         $display("FAIL stall_release: start/din=%b/%h required 1/%h", bus.spi_start, bus.spi_din, c[23:16]);
      end
      @(negedge clk);
      tests_run++;
      if (bus.spi_start !== 1'b0 || sent_q.size() != n0 + 1) begin
         tests_failed++;
         $display("FAIL stall_single_pulse: start=%b starts=%0d required 0 and 1", bus.spi_start, sent_q.size() - n0);
      end
      wait_done(id, cyc, "stall");
      bus.req0 = 1'b0;
      tests_run++;
      if (id !== 0) begin
         tests_failed++;
         $display("FAIL stall_grant: done from requester %0d required 0", id);
      end
      check_bytes(n0, c, "stall");
   endtask

   task automatic test_cmd_change();
      do_txn(1'b0, 1'b1, 24'h123456, 24'h0A2D02, 1'b0, 1'b1, 24'hFFFFFF, 2, "cmd_change");
   endtask

   task automatic test_alternate();
      int          id, cyc, exp_id, n0;
      logic [23:0] c0, c1, exp_cmd;
      c0 = 24'($urandom);
      c1 = 24'($urandom);
      byte_time = 1;
      @(negedge clk);
      reset = 1'b0;
      bus.cmd0 = c0;
      bus.cmd1 = c1;
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_last = 1;
      for (int k = 0; k < 4; k++) begin
         n0 = sent_q.size();
         wait_done(id, cyc, "alternate");
         exp_id = model_grant(1'b1, 1'b1, model_last);
         model_last = exp_id;
         exp_cmd = (exp_id == 1) ? c1 : c0;
         tests_run++;
         if (id !== exp_id) begin
            tests_failed++;
            $display("FAIL alternate_grant%0d: done from requester %0d required %0d", k, id, exp_id);
         end
         check_bytes(n0, exp_cmd, "alternate");
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
   endtask

   task automatic test_reset_abort();
      int          id, cyc, n0, n1, guard;
      logic [23:0] c;
      wait_busy(1'b0, "abort");
      byte_time = 3;
      c = 24'($urandom);
      n0 = sent_q.size();
      bus.cmd1 = c;
      bus.req1 = 1'b1;
      guard = 0;
      while (sent_q.size() < n0 + 2 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      tests_run++;
      if ({bus.cs, bus.busy, bus.spi_start} !== 3'b100) begin
         tests_failed++;
         $display("FAIL abort_immediate: cs/busy/start=%b required 100", {bus.cs, bus.busy, bus.spi_start});
      end
      repeat (3) begin
         @(negedge clk);
         tests_run++;
         if ({bus.done0, bus.done1} !== 2'b00) begin
            tests_failed++;
            $display("FAIL abort_no_done: done0/done1=%b required 00", {bus.done0, bus.done1});
         end
      end
      n1 = sent_q.size();
      reset = 1'b1;
      model_last = model_grant(1'b0, 1'b1, 1);
      wait_done(id, cyc, "abort_fresh");
      bus.req1 = 1'b0;
      tests_run++;
      if (id !== 1) begin
         tests_failed++;
         $display("FAIL abort_fresh_grant: done from requester %0d required 1", id);
      end
      check_bytes(n1, c, "abort_fresh");
   endtask

   task automatic test_spurious_tick();
      logic [7:0] r;
      int         n0;
      wait_busy(1'b0, "tick_idle");
      byte_time = 2;
      r = bus.rdata;
      n0 = sent_q.size();
      inject_tick = 1'b1;
      repeat (4) @(negedge clk);
      tests_run++;
      if ({bus.busy, bus.rdata} !== {1'b0, r} || sent_q.size() != n0) begin
         tests_failed++;
         $display("FAIL tick_idle: busy=%b rdata=%h starts=%0d required 0/%h/0", bus.busy, bus.rdata,
                  sent_q.size() - n0, r);
      end
      do_txn(1'b1, 1'b0, 24'($urandom), 24'($urandom), 1'b0, 1'b0, 24'h0, 2, "tick_pre");
      @(negedge clk);
      r = bus.rdata;
      inject_tick = 1'b1;
      wait_busy(1'b0, "tick_gap");
      tests_run++;
      if (bus.rdata !== r) begin
         tests_failed++;
         $display("FAIL tick_gap_rdata: rdata=%h required %h", bus.rdata, r);
      end
      do_txn(1'b0, 1'b1, 24'($urandom), 24'($urandom), 1'b0, 1'b0, 24'h0, 1, "tick_post");
   endtask

   task automatic test_random();
      int pat;
      for (int i = 0; i < 24; i++) begin
         pat = $urandom_range(0, 2);
         do_txn(pat != 1, pat != 0, 24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 24'($urandom), $urandom_range(1, 4), $sformatf("rand%0d", i));
      end
   endtask

   initial begin
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.cmd0 = '0;
      bus.cmd1 = '0;
      bus.spi_ready = 1'b1;
      bus.spi_done_tick = 1'b0;
      bus.spi_dout = '0;
      reset = 1'b1;
      fork
         master_loop();
         monitor_loop();
      join_none
      test_reset();
      test_single();
      test_ready_stall();
      test_cmd_change();
      test_alternate();
      test_reset_abort();
      test_spurious_tick();
      test_random();
      wait_busy(1'b0, "final");
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
